// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter sharing one serial bus master between NUM_REQ requesters.
// Grants are held for a whole transaction, optionally extended by a lock, and
// a watchdog revokes locked grants that sit idle for HOLD_TIMEOUT cycles.
module serial_bus_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUS_BITS     = 16,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic [NUM_REQ-1:0]          in_req_enable,
  input  logic [NUM_REQ*BUS_BITS-1:0] in_req_data,
  input  logic [NUM_REQ-1:0]          in_req_lock,
  output logic [NUM_REQ-1:0]          out_req_ready,
  output logic [NUM_REQ-1:0]          out_req_next_word,
  output logic [NUM_REQ-1:0]          out_grant,
  input  logic                        in_bus_ready,
  input  logic                        in_bus_next_word,
  output logic                        out_bus_enable,
  output logic [BUS_BITS-1:0]         out_bus_data
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANTED = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_gidx;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;

  logic               w_pick_valid;
  logic [IW-1:0]      w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic               w_en_g;
  logic               w_lock_g;
  logic               w_end;
  logic               w_wd;
  logic [CW-1:0]      w_cnt_inc;
  logic [BUS_BITS-1:0] w_data [NUM_REQ];

  // Round-robin search starting just after the last-served requester
  always_comb begin
    logic [IW-1:0] v_cand;
    w_pick_valid  = 1'b0;
    w_pick_idx    = '0;
    w_pick_onehot = '0;
    v_cand        = '0;
    // Walk from the farthest candidate back to the nearest so the nearest wins
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      v_cand = IW'((32'(r_ptr) + k) % NUM_REQ);
      if (in_req_enable[v_cand]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = v_cand;
      end
    end
    if (w_pick_valid) begin
      w_pick_onehot[w_pick_idx] = 1'b1;
    end
  end

  // End-of-transaction and watchdog conditions for the current owner
  always_comb begin
    w_en_g    = in_req_enable[r_gidx];
    w_lock_g  = in_req_lock[r_gidx];
    w_cnt_inc = r_cnt + CW'(1);
    w_end     = !w_en_g && in_bus_ready && !w_lock_g;
    w_wd      = (HOLD_TIMEOUT != 0) && !w_en_g && w_lock_g &&
                (w_cnt_inc == CW'(HOLD_TIMEOUT));
  end

  // Arbitration state machine: Idle -> Granted -> Release -> Idle
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= IW'(NUM_REQ - 1);
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (in_bus_ready && w_pick_valid) begin
            r_gidx  <= w_pick_idx;
            r_grant <= w_pick_onehot;
            r_state <= S_GRANTED;
          end
        end
        S_GRANTED: begin
          if (w_end || w_wd) begin
            r_grant <= '0;
            r_cnt   <= '0;
            r_state <= S_RELEASE;
          end else if (!w_en_g && w_lock_g) begin
            r_cnt <= w_cnt_inc;
          end else begin
            r_cnt <= '0;
          end
        end
        S_RELEASE: begin
          r_ptr   <= r_gidx;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Split the flat data bus into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_data[i] = in_req_data[i*BUS_BITS +: BUS_BITS];
    end
  end

  // Route the bus to and from the granted requester only
  always_comb begin
    out_grant         = r_grant;
    out_bus_enable    = 1'b0;
    out_bus_data      = '0;
    out_req_ready     = '0;
    out_req_next_word = '0;
    if (|r_grant) begin
      out_bus_enable            = w_en_g;
      out_bus_data              = w_data[r_gidx];
      out_req_ready[r_gidx]     = in_bus_ready;
      out_req_next_word[r_gidx] = in_bus_next_word;
    end
  end

  // Grant is never shared, and the bus is only driven under a single grant
  a_grant_onehot0 : assert property (@(posedge in_clk) disable iff (!in_rst)
    $onehot0(out_grant));
  a_enable_granted : assert property (@(posedge in_clk) disable iff (!in_rst)
    out_bus_enable |-> $onehot(out_grant));

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Bench for serial_bus_arbiter: table vectors, directed corner cases and
// random traffic checked against a transaction-level reference model.
module tb_serial_bus_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned BB = 16;
  localparam int unsigned HT = 8;

  logic          in_clk;
  logic          in_rst;
  logic [N-1:0]  en;
  logic [N*BB-1:0] data;
  logic [N-1:0]  lock;
  logic [N-1:0]  o_ready;
  logic [N-1:0]  o_nw;
  logic [N-1:0]  o_grant;
  logic          rdy;
  logic          nw;
  logic          o_en;
  logic [BB-1:0] o_data;

  int vectors;
  int errors;

  // Reference model: owner of the bus, last served, cooldown, idle-locked run
  int m_owner;
  int m_last;
  int m_cool;
  int m_cnt;

  serial_bus_arbiter #(.NUM_REQ(N), .BUS_BITS(BB), .HOLD_TIMEOUT(HT)) dut (
    .in_clk           (in_clk),
    .in_rst           (in_rst),
    .in_req_enable    (en),
    .in_req_data      (data),
    .in_req_lock      (lock),
    .out_req_ready    (o_ready),
    .out_req_next_word(o_nw),
    .out_grant        (o_grant),
    .in_bus_ready     (rdy),
    .in_bus_next_word (nw),
    .out_bus_enable   (o_en),
    .out_bus_data     (o_data)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] lock;
    logic         rdy;
    logic         nw;
    logic [N-1:0] g;
    logic         be;
  } vec_t;

  vec_t tbl [14];

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_cool  = 0;
    m_cnt   = 0;
  endtask

  // One clock of the model, from the inputs present before the edge
  task automatic model_step();
    int  cand;
    bit  found;
    if (m_owner >= 0) begin
      if (!en[m_owner] && lock[m_owner]) m_cnt++;
      else m_cnt = 0;
      if ((!en[m_owner] && rdy && !lock[m_owner]) || (HT > 0 && m_cnt >= HT)) begin
        m_last  = m_owner;
        m_owner = -1;
        m_cool  = 1;
        m_cnt   = 0;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else if (rdy) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        cand = (m_last + k) % N;
        if (!found && en[cand]) begin
          found   = 1;
          m_owner = cand;
        end
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [N-1:0]  eg, er, enw;
    logic          ee;
    logic [BB-1:0] ed;
    eg = '0; er = '0; enw = '0; ee = 1'b0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner]  = 1'b1;
      er[m_owner]  = rdy;
      enw[m_owner] = nw;
      ee           = en[m_owner];
      ed           = data[m_owner*BB +: BB];
    end
    vectors++;
    if (o_grant !== eg || o_en !== ee || o_data !== ed || o_ready !== er || o_nw !== enw) begin
      errors++;
      $display("FAIL %s model: got g=%b en=%b d=%h rdy=%b nw=%b, want g=%b en=%b d=%h rdy=%b nw=%b",
               name, o_grant, o_en, o_data, o_ready, o_nw, eg, ee, ed, er, enw);
    end
  endtask

  task automatic check_grant(input string name, input logic [N-1:0] exp);
    vectors++;
    if (o_grant !== exp) begin
      errors++;
      $display("FAIL %s grant: got %b, want %b", name, o_grant, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set
  task automatic cyc(input string name, input bit chk, input logic [N-1:0] exp);
    #1;
    check_model(name);
    if (chk) check_grant(name, exp);
    @(posedge in_clk);
    if (in_rst) model_step();
    @(negedge in_clk);
  endtask

  task automatic idle_inputs();
    en = '0; lock = '0; rdy = 1'b1; nw = 1'b0;
  endtask

  task automatic do_reset();
    in_rst = 1'b0;
    idle_inputs();
    model_reset();
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b1;
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    data    = {16'h2A03, 16'h1B02, 16'h0C01};
    in_rst  = 1'b0;
    en = '1; lock = '0; rdy = 1'b1; nw = 1'b1;
    model_reset();

    // Outputs are silent in reset even with every request up
    @(negedge in_clk);
    vectors++;
    if (o_grant !== '0 || o_en !== 1'b0 || o_data !== '0 || o_ready !== '0 || o_nw !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got g=%b en=%b d=%h, want all 0", o_grant, o_en, o_data);
    end

    // Single requester and contention, from reset
    tbl[0]  = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[1]  = '{3'b011, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1};
    tbl[2]  = '{3'b011, 3'b000, 1'b0, 1'b1, 3'b001, 1'b1};
    tbl[3]  = '{3'b010, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0};
    tbl[4]  = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[5]  = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[6]  = '{3'b011, 3'b000, 1'b1, 1'b0, 3'b010, 1'b1};
    tbl[7]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b010, 1'b0};
    tbl[8]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[9]  = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[10] = '{3'b001, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1};
    tbl[11] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b001, 1'b0};
    tbl[12] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    tbl[13] = '{3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; lock = tbl[i].lock; rdy = tbl[i].rdy; nw = tbl[i].nw;
      #1;
      vectors++;
      if (o_grant !== tbl[i].g || o_en !== tbl[i].be) begin
        errors++;
        $display("FAIL table[%0d]: got g=%b en=%b, want g=%b en=%b", i, o_grant, o_en, tbl[i].g, tbl[i].be);
      end
      cyc("table", 1'b0, '0);
    end

    // Lock: requester 1 keeps the bus for 5 words while requester 0 waits
    do_reset();
    en = 3'b010; lock = 3'b010;
    cyc("lock_req", 1'b1, 3'b000);
    for (int w = 0; w < 5; w++) begin
      en = 3'b011; nw = 1'b0;
      cyc("lock_word", 1'b1, 3'b010);
      nw = 1'b1;
      cyc("lock_take", 1'b1, 3'b010);
      nw = 1'b0; en = 3'b001;
      cyc("lock_gap", 1'b1, 3'b010);
    end
    lock = 3'b000;
    cyc("lock_drop", 1'b1, 3'b010);
    cyc("lock_rel", 1'b1, 3'b000);
    cyc("lock_idle", 1'b1, 3'b000);
    cyc("lock_next", 1'b1, 3'b001);

    // Watchdog: idle locked grant revoked after 8 cycles
    do_reset();
    en = 3'b001; lock = 3'b001;
    cyc("wd_req", 1'b1, 3'b000);
    en = 3'b010;
    for (int c = 0; c < 8; c++) cyc("wd_hold", 1'b1, 3'b001);
    cyc("wd_rel", 1'b1, 3'b000);
    cyc("wd_idle", 1'b1, 3'b000);
    cyc("wd_next", 1'b1, 3'b010);

    // Busy master: no grant until ready
    do_reset();
    en = 3'b001; rdy = 1'b0;
    for (int c = 0; c < 4; c++) cyc("busy_wait", 1'b1, 3'b000);
    rdy = 1'b1;
    cyc("busy_ready", 1'b1, 3'b000);
    rdy = 1'b0;
    cyc("busy_grant", 1'b1, 3'b001);

    // Async reset in the middle of a word
    nw = 1'b1;
    #3;
    in_rst = 1'b0;
    #1;
    vectors++;
    if (o_grant !== '0 || o_en !== 1'b0 || o_data !== '0 || o_ready !== '0 || o_nw !== '0) begin
      errors++;
      $display("FAIL async_reset: got g=%b en=%b d=%h rdy=%b nw=%b, want all 0", o_grant, o_en, o_data, o_ready, o_nw);
    end
    model_reset();
    @(negedge in_clk);
    @(negedge in_clk);
    in_rst = 1'b1;
    en = 3'b011; rdy = 1'b1; nw = 1'b0; lock = '0;
    cyc("post_rst_req", 1'b1, 3'b000);
    cyc("post_rst_grant", 1'b1, 3'b001);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      en   = N'($urandom_range(0, 7));
      lock = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : '0;
      rdy  = ($urandom_range(0, 3) != 0);
      nw   = 1'($urandom_range(0, 1));
      data = {16'($urandom), 16'($urandom), 16'($urandom)};
      cyc("random", 1'b0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
